pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Instruction-side partner of the single-cycle control decoder. It owns the PC, fetches words
//  over a req/ack handshake and presents each instruction to the decoder (op=instr[31:26],
//  funct=instr[5:0]). It consumes the decoder's Beq/Bne/J/Jal/Jr flags plus ALU zero/rs data,
//  then computes the next PC. No delay slot. Misaligned jump targets are trapped.
// PARAMETERS
//  RESET_PC   32'h0040_0000   PC loaded on reset
// PORTS
//  clk         in   1   clock, all state updates on rising edge
//  reset       in   1   synchronous, active-high
//  imem_req    out  1   fetch request; high only in state FETCH
//  imem_addr   out  32  fetch address, equals pc
//  imem_ack    in   1   fetch complete; imem_rdata valid this cycle
//  imem_rdata  in   32  fetched instruction word
//  instr       out  32  latched instruction, stable from ISSUE through end of EXEC
//  instr_valid out  1   one-cycle pulse in ISSUE: decoder inputs newly valid
//  exec_done   in   1   datapath finished; Beq..Jr, zero, rs_data valid this cycle
//  Beq,Bne,J,Jal,Jr in 1 each  control flags from decoder
//  zero        in   1   ALU zero result
//  rs_data     in   32  register rs value (Jr target)
//  pc          out  32  current instruction address
//  link_addr   out  32  pc+4 (written to $31 by datapath on Jal)
//  misalign    out  1   sticky trap flag
//  retired     out  32  count of completed instructions, wraps mod 2^32
// BEHAVIOUR
//  Reset: state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, misalign=0, retired=0,
//   link_addr=RESET_PC+4; imem_req=1 in first cycle after reset deasserts. Reset wins over all.
//  States: FETCH -> ISSUE -> EXEC -> FETCH; HALT terminal (exit only via reset).
//  FETCH: imem_req=1, imem_addr=pc held stable until ack. On imem_ack: instr<=imem_rdata, go ISSUE.
//   Ack may arrive in the first FETCH cycle (min fetch latency 1 cycle). Ack outside FETCH ignored.
//  ISSUE: instr_valid=1 for exactly this cycle; go EXEC.
//  EXEC: wait for exec_done (any number of cycles, including the first EXEC cycle). On exec_done:
//   retired<=retired+1; compute next, pc<=next, go FETCH; flags ignored when exec_done=0.
//  Next-PC, pc4=pc+4, priority top-down:
//   Jr            -> rs_data
//   J or Jal      -> {pc4[31:28], instr[25:0], 2'b00}
//   Beq & zero    -> pc4 + {{14{instr[15]}}, instr[15:0], 2'b00}
//   Bne & ~zero   -> same branch target
//   otherwise     -> pc4
//  All adds 32-bit, carry-out discarded (wrap at 2^32).
//  Misalign: if selected next[1:0]!=0 at exec_done: misalign<=1, pc unchanged, retired still
//   increments, go HALT. HALT: imem_req=0, instr_valid=0, all outputs hold.
//  Reset mid-fetch: pending ack in reset cycle ignored; refetch from RESET_PC.
// TESTING
//  1 RESET_PC=0x00400000, release reset -> next cycle imem_req=1, addr=0x00400000; ack
//    0x00000020 -> instr_valid pulse, instr=0x00000020; exec_done, no flags -> pc=0x00400004, retired=1.
//  2 pc=0x00000100, instr imm=0xFFFF: Beq=1,zero=1 -> pc=0x00000100; Bne=1,zero=1 -> pc=0x00000104.
//  3 pc=0x00400010, instr=0x0C100008 (jal), Jal=1 -> link_addr=0x00400014 at ISSUE; next pc=0x00400020.
//  4 Jr=1, Beq=1, zero=1, rs_data=0x00400040 -> pc=0x00400040 (Jr priority); rs_data=0x00400031
//    -> misalign=1, HALT, imem_req stays 0 for 20 cycles until reset.
//  5 imem_ack low 5 cycles -> imem_req=1 and imem_addr constant; assert reset in cycle 3 with
//    ack=1 -> instr unchanged (0), next fetch addr=RESET_PC, retired=0.
//  6 exec_done held low 10 cycles in EXEC -> pc, instr, retired constant; instr_valid pulsed once only.

Source files
------------

// File: rtl/pc_sequencer.sv
// Instruction-side sequencer: owns the PC, fetches over a req/ack handshake,
// issues each word to the decoder and resolves the next PC once execution completes.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        Beq,
    input  logic        Bne,
    input  logic        J,
    input  logic        Jal,
    input  logic        Jr,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic        misalign,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic [31:0] link_reg;
    logic [31:0] retired_reg;
    logic        req_reg;
    logic        valid_reg;
    logic        misalign_reg;

    logic [31:0] pc4;
    logic [31:0] branch_target;
    logic [31:0] pc_next;

    // Next-PC selection; Jr dominates, then jumps, then taken branches.
    always_comb begin
        pc4           = pc_reg + 32'd4;
        branch_target = pc4 + {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
        pc_next       = pc4;
        if (Jr) begin
            pc_next = rs_data;
        end else if (J || Jal) begin
            pc_next = {pc4[31:28], instr_reg[25:0], 2'b00};
        end else if (Beq && zero) begin
            pc_next = branch_target;
        end else if (Bne && !zero) begin
            pc_next = branch_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= FETCH;
            pc_reg       <= RESET_PC;
            instr_reg    <= 32'd0;
            link_reg     <= RESET_PC + 32'd4;
            retired_reg  <= 32'd0;
            req_reg      <= 1'b1;
            valid_reg    <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            case (state_reg)
                FETCH: begin
                    valid_reg <= 1'b0;
                    if (imem_ack) begin
                        instr_reg <= imem_rdata;
                        valid_reg <= 1'b1;
                        req_reg   <= 1'b0;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    valid_reg <= 1'b0;
                    state_reg <= EXEC;
                end
                EXEC: begin
                    if (exec_done) begin
                        retired_reg <= retired_reg + 32'd1;
                        // A misaligned target freezes the PC and parks the sequencer.
                        if (pc_next[1:0] != 2'b00) begin
                            misalign_reg <= 1'b1;
                            state_reg    <= HALT;
                        end else begin
                            pc_reg    <= pc_next;
                            link_reg  <= pc_next + 32'd4;
                            req_reg   <= 1'b1;
                            state_reg <= FETCH;
                        end
                    end
                end
                HALT: begin
                    req_reg   <= 1'b0;
                    valid_reg <= 1'b0;
                end
                default: begin
                    state_reg <= HALT;
                end
            endcase
        end
    end

    assign imem_req    = req_reg;
    assign imem_addr   = pc_reg;
    assign instr       = instr_reg;
    assign instr_valid = valid_reg;
    assign pc          = pc_reg;
    assign link_addr   = link_reg;
    assign misalign    = misalign_reg;
    assign retired     = retired_reg;

endmodule
